// File: rtl/rs_pkg.sv
// Shared types for the reservation station: entry state encoding, the
// "no producer" tag and the entry record.
package rs_pkg;

  // Entry record widths; the station's DATA_W/TAG_W/OP_W must not exceed these.
  localparam int RS_DATA_W = 16;
  localparam int RS_TAG_W  = 4;
  localparam int RS_OP_W   = 3;

  localparam int TAG_NONE = 0;

  typedef enum logic [1:0] {
    ST_FREE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } ent_state_e;

  typedef struct packed {
    ent_state_e           state;
    logic [RS_OP_W-1:0]   op;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_DATA_W-1:0] vk;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_TAG_W-1:0]  qk;
    logic [RS_TAG_W-1:0]  tag;
  } rs_entry_t;

endpackage

// File: rtl/rs_age_picker.sv
// One-hot select of the oldest ready entry; age[j][i] = 1 means j is older than i.
module rs_age_picker #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0]            ready,
  input  logic [DEPTH-1:0][DEPTH-1:0] age,
  output logic [DEPTH-1:0]            sel
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic older;
      older = 1'b0;
      for (int j = 0; j < DEPTH; j++)
        older = older | (ready[j] & age[j][i]);
      sel[i] = ready[i] & ~older;
    end
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station: issue into the lowest free entry, capture CDB results,
// dispatch the oldest ready entry using an age matrix.
module rs_station
  import rs_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = RS_DATA_W,
  parameter int TAG_W  = RS_TAG_W,
  parameter int OP_W   = RS_OP_W
) (
  input  logic                       clk1,
  input  logic                       rst,
  input  logic                       iss_valid,
  output logic                       iss_ready,
  input  logic [OP_W-1:0]            iss_op,
  input  logic [DATA_W-1:0]          iss_vj,
  input  logic [DATA_W-1:0]          iss_vk,
  input  logic [TAG_W-1:0]           iss_qj,
  input  logic [TAG_W-1:0]           iss_qk,
  input  logic [TAG_W-1:0]           iss_tag,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [DATA_W-1:0]          cdb_data,
  output logic                       disp_valid,
  input  logic                       disp_ready,
  output logic [OP_W-1:0]            disp_op,
  output logic [DATA_W-1:0]          disp_vj,
  output logic [DATA_W-1:0]          disp_vk,
  output logic [TAG_W-1:0]           disp_tag,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  rs_entry_t                   ent_q [DEPTH];
  rs_entry_t                   ent_d [DEPTH];
  rs_entry_t                   new_ent;
  logic [DEPTH-1:0][DEPTH-1:0] age_q, age_d;
  logic [OCC_W-1:0]            occ_q;
  logic [DEPTH-1:0]            free_v, rdy_v, busy_v, alloc, sel;
  logic                        iss_fire, disp_fire, cdb_ok;
  logic [RS_TAG_W-1:0]         cdb_tag_e;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      free_v[i] = (ent_q[i].state == ST_FREE);
      rdy_v[i]  = (ent_q[i].state == ST_READY);
      busy_v[i] = ~free_v[i];
    end
  end

  assign alloc     = free_v & (~free_v + DEPTH'(1));
  assign iss_ready = |free_v;
  assign iss_fire  = iss_valid & iss_ready;
  assign disp_valid = |rdy_v;
  assign disp_fire = disp_valid & disp_ready;
  assign cdb_ok    = cdb_valid && (cdb_tag != TAG_W'(TAG_NONE));
  assign cdb_tag_e = RS_TAG_W'(cdb_tag);
  assign occupancy = occ_q;

  rs_age_picker #(.DEPTH(DEPTH)) u_pick (
    .ready (rdy_v),
    .age   (age_q),
    .sel   (sel)
  );

  // Incoming entry, with same-cycle bypass of a matching CDB broadcast
  always_comb begin
    new_ent.op  = RS_OP_W'(iss_op);
    new_ent.tag = RS_TAG_W'(iss_tag);
    new_ent.vj  = RS_DATA_W'(iss_vj);
    new_ent.vk  = RS_DATA_W'(iss_vk);
    new_ent.qj  = RS_TAG_W'(iss_qj);
    new_ent.qk  = RS_TAG_W'(iss_qk);
    if (cdb_ok && iss_qj == cdb_tag) begin
      new_ent.vj = RS_DATA_W'(cdb_data);
      new_ent.qj = '0;
    end
    if (cdb_ok && iss_qk == cdb_tag) begin
      new_ent.vk = RS_DATA_W'(cdb_data);
      new_ent.qk = '0;
    end
    new_ent.state = (new_ent.qj == '0 && new_ent.qk == '0) ? ST_READY : ST_WAIT;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (ent_q[i].state == ST_WAIT) begin
        if (cdb_ok && ent_q[i].qj == cdb_tag_e) begin
          ent_d[i].vj = RS_DATA_W'(cdb_data);
          ent_d[i].qj = '0;
        end
        if (cdb_ok && ent_q[i].qk == cdb_tag_e) begin
          ent_d[i].vk = RS_DATA_W'(cdb_data);
          ent_d[i].qk = '0;
        end
        if (ent_d[i].qj == '0 && ent_d[i].qk == '0)
          ent_d[i].state = ST_READY;
      end
      if (disp_fire && sel[i])
        ent_d[i].state = ST_FREE;
      if (iss_fire && alloc[i])
        ent_d[i] = new_ent;
    end
  end

  // New entry is younger than every currently busy entry
  always_comb begin
    age_d = age_q;
    if (iss_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alloc[i]) begin
          age_d[i] = '0;
          for (int j = 0; j < DEPTH; j++)
            age_d[j][i] = busy_v[j];
        end
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      age_q <= '0;
      occ_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      age_q <= age_d;
      case ({iss_fire, disp_fire})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  always_comb begin
    disp_op  = '0;
    disp_vj  = '0;
    disp_vk  = '0;
    disp_tag = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        disp_op  = OP_W'(ent_q[i].op);
        disp_vj  = DATA_W'(ent_q[i].vj);
        disp_vk  = DATA_W'(ent_q[i].vk);
        disp_tag = TAG_W'(ent_q[i].tag);
      end
    end
  end

endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: issue, CDB capture/bypass, full station,
// age ordering and reset override.
module tb_rs_station;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        iss_valid, iss_ready;
  logic [2:0]  iss_op;
  logic [15:0] iss_vj, iss_vk;
  logic [3:0]  iss_qj, iss_qk, iss_tag;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [15:0] cdb_data;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_op;
  logic [15:0] disp_vj, disp_vk;
  logic [3:0]  disp_tag;
  logic [2:0]  occupancy;

  int ncmp = 0;
  int nerr = 0;

  rs_station dut (
    .clk1(clk1), .rst(rst),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op),
    .iss_vj(iss_vj), .iss_vk(iss_vk), .iss_qj(iss_qj), .iss_qk(iss_qk),
    .iss_tag(iss_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_tag(disp_tag),
    .occupancy(occupancy)
  );

  always #5 clk1 = ~clk1;

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic iss(input logic [3:0] tag, input logic [15:0] vj, input logic [15:0] vk,
                     input logic [3:0] qj, input logic [3:0] qk);
    iss_valid = 1'b1;
    iss_op    = 3'd1;
    iss_tag   = tag;
    iss_vj    = vj;
    iss_vk    = vk;
    iss_qj    = qj;
    iss_qk    = qk;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    rst = 1'b1; iss_valid = 0; iss_op = 0; iss_vj = 0; iss_vk = 0;
    iss_qj = 0; iss_qk = 0; iss_tag = 0; cdb_valid = 0; cdb_tag = 0;
    cdb_data = 0; disp_ready = 0;
    tick();
    rst = 1'b0;
    chk("rst_occ", occupancy, 0);
    chk("rst_iss_ready", iss_ready, 1);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_disp_vj", disp_vj, 0);
    chk("rst_disp_tag", disp_tag, 0);

    // Simple ready issue then dispatch
    iss(4'd3, 16'd5, 16'd7, 4'd0, 4'd0);
    tick();
    iss_valid = 0;
    chk("ready_valid", disp_valid, 1);
    chk("ready_op", disp_op, 1);
    chk("ready_vj", disp_vj, 5);
    chk("ready_vk", disp_vk, 7);
    chk("ready_tag", disp_tag, 3);
    chk("ready_occ", occupancy, 1);
    disp_ready = 1;
    tick();
    chk("ready_occ_after", occupancy, 0);
    chk("idle_valid", disp_valid, 0);
    chk("idle_vj_zero", disp_vj, 0);

    // CDB capture; tag-0 broadcast must not touch the waiting entry
    iss(4'd5, 16'd0, 16'd1, 4'd2, 4'd0);
    tick();
    iss_valid = 0;
    chk("wait_valid", disp_valid, 0);
    chk("wait_occ", occupancy, 1);
    cdb(4'd0, 16'h1234);
    tick();
    chk("tag0_valid", disp_valid, 0);
    cdb(4'd2, 16'h0AAA);
    tick();
    cdb_valid = 0;
    chk("cap_valid", disp_valid, 1);
    chk("cap_vj", disp_vj, 16'h0AAA);
    chk("cap_vk", disp_vk, 1);
    chk("cap_tag", disp_tag, 5);
    tick();
    chk("cap_occ_after", occupancy, 0);

    // Same-cycle bypass
    disp_ready = 0;
    iss(4'd7, 16'd3, 16'd0, 4'd0, 4'd6);
    cdb(4'd6, 16'd9);
    tick();
    iss_valid = 0; cdb_valid = 0;
    chk("byp_valid", disp_valid, 1);
    chk("byp_vj", disp_vj, 3);
    chk("byp_vk", disp_vk, 9);
    disp_ready = 1;
    tick();
    chk("byp_occ_after", occupancy, 0);

    // Fill the station
    disp_ready = 0;
    for (int t = 1; t <= 4; t++) begin
      iss(4'(t), 16'(t), 16'd0, 4'd0, 4'd0);
      tick();
    end
    chk("full_occ", occupancy, 4);
    chk("full_iss_ready", iss_ready, 0);
    iss(4'd9, 16'd9, 16'd0, 4'd0, 4'd0);
    tick();
    chk("full_ignore_occ", occupancy, 4);
    chk("full_oldest", disp_tag, 1);
    disp_ready = 1;
    tick();
    chk("full_refuse_occ", occupancy, 3);
    chk("full_ready_again", iss_ready, 1);
    disp_ready = 0;
    tick();
    iss_valid = 0;
    chk("full_accept_occ", occupancy, 4);
    chk("full_iss_ready2", iss_ready, 0);
    disp_ready = 1;
    chk("drain_0", disp_tag, 2); tick();
    chk("drain_1", disp_tag, 3); tick();
    chk("drain_2", disp_tag, 4); tick();
    chk("drain_3", disp_tag, 9); tick();
    chk("drain_occ", occupancy, 0);

    // Age order beats index order after entry 0 is recycled
    disp_ready = 0;
    for (int t = 1; t <= 3; t++) begin
      iss(4'(t), 16'd0, 16'd0, 4'd0, 4'd0);
      tick();
    end
    iss_valid = 0;
    chk("age_first", disp_tag, 1);
    disp_ready = 1;
    tick();
    disp_ready = 0;
    iss(4'd4, 16'd0, 16'd0, 4'd0, 4'd0);
    tick();
    iss_valid = 0;
    chk("age_occ", occupancy, 3);
    disp_ready = 1;
    chk("age_0", disp_tag, 2); tick();
    chk("age_1", disp_tag, 3); tick();
    chk("age_2", disp_tag, 4); tick();
    chk("age_occ_after", occupancy, 0);

    // Reset overrides issue, dispatch and CDB
    disp_ready = 0;
    iss(4'd1, 16'd1, 16'd1, 4'd0, 4'd0); tick();
    iss(4'd2, 16'd2, 16'd2, 4'd5, 4'd0); tick();
    iss(4'd3, 16'd3, 16'd3, 4'd0, 4'd0); tick();
    chk("pre_rst_occ", occupancy, 3);
    rst = 1; disp_ready = 1;
    iss(4'd8, 16'd8, 16'd8, 4'd0, 4'd0);
    cdb(4'd5, 16'h00FF);
    tick();
    rst = 0; iss_valid = 0; cdb_valid = 0; disp_ready = 0;
    chk("mid_rst_occ", occupancy, 0);
    chk("mid_rst_disp_valid", disp_valid, 0);
    chk("mid_rst_iss_ready", iss_ready, 1);
    chk("mid_rst_vj", disp_vj, 0);
    tick();
    chk("post_rst_valid", disp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
